adt7301_reader: RTL and testbench
=================================

# adt7301_reader

SPI master that autonomously reads the ADT7301 temperature sensor from the FPGA side, the initiating end of the sensor's serial protocol. It sits beside the MCU pass-through path to the ADT7301 and yields the bus whenever the MCU selects the sensor. The signed 14-bit temperature result is latched for the register and SPI logic to report.

## Interface
- CLK_DIV, 6: SCLK half-period in sys_clk cycles (≥2); 24 MHz / 12 = 2 MHz SCLK
- POLL_PERIOD, 2400000: sys_clk cycles between automatic conversions (100 ms at 24 MHz); used only with ADT_AUTOPOLL_EN
- sys_clk  input  1  single block clock (sys_2xclk domain, 24 MHz)
- sys_rst  input  1  asynchronous, active-low reset
- start  input  1  one-cycle read request
- mcu_active  input  1  high while the MCU owns the sensor bus (adt_cs asserted by MCU); synchronous to sys_clk
- adt_miso  input  1  sensor DOUT
- adt_sclk  output  1  SCLK, idles high
- adt_cs_n  output  1  sensor chip select, active low
- adt_mosi  output  1  sensor DIN, held 0 (normal mode command)
- temp_data  output  16  last good reading, 14-bit two's complement sign-extended from bit 13, LSB = 1/32 °C
- temp_valid  output  1  one-cycle pulse when temp_data updates
- busy  output  1  high from transfer start until return to IDLE
- aborted  output  1  one-cycle pulse when a transfer is dropped for mcu_active

## Operation
- Reset values: adt_cs_n=1, adt_sclk=1, adt_mosi=0, temp_data=0x0000, temp_valid=0, busy=0, aborted=0; FSM in IDLE; poll timer cleared.
- States: IDLE → SETUP → SHIFT → HOLD → IDLE.
- IDLE: a trigger (start, or poll timer expiry) with mcu_active=0 enters SETUP. If trigger and mcu_active coincide, MCU wins and the trigger is dropped, not queued. start while busy is ignored.
- SETUP: adt_cs_n=0, SCLK high, for CLK_DIV cycles.
- SHIFT: 16 SCLK periods, MSB first. SCLK falls (sensor drives), stays low CLK_DIV cycles, rises, stays high CLK_DIV cycles. adt_miso is shifted into a 16-bit register on the sys_clk edge that drives SCLK high.
- HOLD: after the 16th rising edge, CLK_DIV cycles, then adt_cs_n=1 and return to IDLE. On that same edge, temp_data = {{2{sr[13]}}, sr[13:0]} and temp_valid pulses. Bits 15:14 of the frame (leading zeros) are discarded without being checked.
- Arbitration: mcu_active=1 in SETUP/SHIFT/HOLD aborts the transfer on the next edge. adt_cs_n=1, adt_sclk=1, aborted pulses, temp_data is unchanged, no temp_valid, and the FSM enters IDLE.
- Reset mid-transfer: all outputs return to their reset values immediately (asynchronously); no partial data is latched.

## Timing
- Transfer duration: CS low to CS high = CLK_DIV + 32·CLK_DIV + CLK_DIV = 34·CLK_DIV cycles (204 at default).
- start at cycle 0 → adt_cs_n low at cycle 1 → adt_cs_n high, temp_valid, temp_data at cycle 1+34·CLK_DIV.
- busy is high exactly while the FSM is not in IDLE.
- aborted is asserted 1 cycle after mcu_active is sampled high.
- Outputs are registered; no combinational path from inputs to outputs.

## Configuration
- ADT_AUTOPOLL_EN defined: a free-running counter issues a trigger every POLL_PERIOD cycles, counted from reset release or from the previous trigger. A trigger arriving while busy or while mcu_active is set is dropped, and the counter restarts. start remains functional.
- Not defined: no poll counter is synthesised; conversions occur only on start. POLL_PERIOD is unused.

## Test plan
- Reset: hold sys_rst=0 → all outputs at reset values; release, 1000 idle cycles with no start (macro off) → adt_cs_n stays 1.
- Positive read: CLK_DIV=6, start, sensor model drives frame 0x0320 → temp_data=0x0320 (+25 °C), temp_valid one cycle at start+205, 16 SCLK rising edges, adt_mosi=0 throughout.
- Negative read: frame 0x3B00 → temp_data=0xFB00 (−40 °C); frame 0x3FFF → 0xFFFF.
- Abort: raise mcu_active after the 8th rising SCLK edge → adt_cs_n=1 and aborted pulse one cycle later; temp_data keeps its previous value; start with mcu_active=1 → no CS activity.
- Autopoll (ADT_AUTOPOLL_EN, POLL_PERIOD=500) → CS falling edges exactly 500 cycles apart; start issued mid-transfer → ignored.
- Reset mid-SHIFT → adt_cs_n=1 and adt_sclk=1 asynchronously, busy=0, temp_data=0x0000, no temp_valid.

Source files
------------

// File: rtl/adt7301_reader.sv
// SPI master that autonomously reads the ADT7301 temperature sensor and yields the bus to the MCU.
// Optional feature: define ADT_AUTOPOLL_EN to add a free-running conversion timer of POLL_PERIOD cycles.
module adt7301_reader #(
    parameter int CLK_DIV     = 6,
    parameter int POLL_PERIOD = 2400000
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        start,
    input  logic        mcu_active,
    input  logic        adt_miso,
    output logic        adt_sclk,
    output logic        adt_cs_n,
    output logic        adt_mosi,
    output logic [15:0] temp_data,
    output logic        temp_valid,
    output logic        busy,
    output logic        aborted
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [4:0] HALF_LAST = 5'd31;

    logic [1:0]       state_r;
    logic [DIV_W-1:0] div_cnt_r;
    logic [4:0]       half_cnt_r;
    logic [13:0]      shift_r;
    logic             div_done_s;
    logic             poll_hit_s;
    logic             trigger_s;

    // Normal-mode command: DIN is never driven high.
    assign adt_mosi = 1'b0;

`ifdef ADT_AUTOPOLL_EN
    localparam int POLL_W = $clog2(POLL_PERIOD + 1);
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_PERIOD - 1);

    logic [POLL_W-1:0] poll_cnt_r;

    // Poll timer restarts on every expiry, whether or not the trigger is taken.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            poll_cnt_r <= {POLL_W{1'b0}};
        end else if (poll_cnt_r == POLL_LAST) begin
            poll_cnt_r <= {POLL_W{1'b0}};
        end else begin
            poll_cnt_r <= poll_cnt_r + POLL_W'(1);
        end
    end

    assign poll_hit_s = (poll_cnt_r == POLL_LAST);
`else
    assign poll_hit_s = (POLL_PERIOD < 0);
`endif

    // Read request sources; only consumed while idle.
    always_comb begin
        trigger_s  = 1'b0;
        div_done_s = 1'b0;
        trigger_s  = start | poll_hit_s;
        div_done_s = (div_cnt_r == DIV_LAST);
    end

    // Transfer FSM with SCLK generation, data capture and MCU arbitration.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_r    <= ST_IDLE;
            div_cnt_r  <= {DIV_W{1'b0}};
            half_cnt_r <= 5'd0;
            shift_r    <= 14'd0;
            adt_sclk   <= 1'b1;
            adt_cs_n   <= 1'b1;
            temp_data  <= 16'h0000;
            temp_valid <= 1'b0;
            busy       <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            temp_valid <= 1'b0;
            aborted    <= 1'b0;
            if (state_r == ST_IDLE) begin
                div_cnt_r <= {DIV_W{1'b0}};
                if (trigger_s && !mcu_active) begin
                    state_r  <= ST_SETUP;
                    adt_cs_n <= 1'b0;
                    adt_sclk <= 1'b1;
                    busy     <= 1'b1;
                end else begin
                    state_r  <= ST_IDLE;
                end
            end else if (mcu_active) begin
                // MCU owns the bus: release it at once and discard the partial frame.
                state_r  <= ST_IDLE;
                adt_cs_n <= 1'b1;
                adt_sclk <= 1'b1;
                busy     <= 1'b0;
                aborted  <= 1'b1;
            end else begin
                div_cnt_r <= div_done_s ? {DIV_W{1'b0}} : div_cnt_r + DIV_W'(1);
                case (state_r)
                    ST_SETUP: begin
                        if (div_done_s) begin
                            state_r    <= ST_SHIFT;
                            adt_sclk   <= 1'b0;
                            half_cnt_r <= 5'd0;
                        end
                    end
                    ST_SHIFT: begin
                        if (div_done_s) begin
                            if (half_cnt_r == HALF_LAST) begin
                                state_r <= ST_HOLD;
                            end else begin
                                half_cnt_r <= half_cnt_r + 5'd1;
                                adt_sclk   <= ~adt_sclk;
                                // Sample on the rising edge; the two leading zeros fall off the top.
                                if (!adt_sclk) begin
                                    shift_r <= {shift_r[12:0], adt_miso};
                                end
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (div_done_s) begin
                            state_r    <= ST_IDLE;
                            adt_cs_n   <= 1'b1;
                            busy       <= 1'b0;
                            temp_valid <= 1'b1;
                            temp_data  <= {{2{shift_r[13]}}, shift_r};
                        end
                    end
                    default: begin
                        state_r  <= ST_IDLE;
                        adt_cs_n <= 1'b1;
                        adt_sclk <= 1'b1;
                        busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adt7301_reader.sv
// Directed self-checking bench for adt7301_reader with a behavioural ADT7301 DOUT model.
// With ADT_AUTOPOLL_EN defined only the poll-spacing scenario runs.
module tb_adt7301_reader;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic        start = 1'b0;
    logic        mcu_active = 1'b0;
    logic        adt_miso = 1'b0;
    logic        adt_sclk, adt_cs_n, adt_mosi;
    logic [15:0] temp_data;
    logic        temp_valid, busy, aborted;

    logic [15:0] sens_frame = 16'h0000;
    logic [3:0]  sens_idx = 4'd15;
    int          rise_cnt = 0;
    int          cs_falls = 0;
    int          mosi_bad = 0;
    int          valid_cnt = 0;
    longint      fall_t [0:15];

    int n_chk = 0;
    int n_err = 0;

    adt7301_reader #(.CLK_DIV(6), .POLL_PERIOD(500)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .mcu_active(mcu_active),
        .adt_miso(adt_miso), .adt_sclk(adt_sclk), .adt_cs_n(adt_cs_n), .adt_mosi(adt_mosi),
        .temp_data(temp_data), .temp_valid(temp_valid), .busy(busy), .aborted(aborted)
    );

    always #5 sys_clk = ~sys_clk;

    // Sensor: reload on CS fall, present the next bit on each SCLK fall.
    always @(negedge adt_sclk or negedge adt_cs_n) begin
        if (adt_sclk) begin
            sens_idx <= 4'd15;
        end else if (!adt_cs_n) begin
            adt_miso <= sens_frame[sens_idx];
            sens_idx <= sens_idx - 4'd1;
        end
    end

    always @(posedge adt_sclk) if (!adt_cs_n) rise_cnt <= rise_cnt + 1;

    always @(negedge adt_cs_n) begin
        fall_t[cs_falls % 16] <= $time;
        cs_falls <= cs_falls + 1;
    end

    always @(posedge sys_clk) begin
        if (!adt_cs_n && adt_mosi) mosi_bad <= mosi_bad + 1;
        if (temp_valid) valid_cnt <= valid_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge sys_clk);
    endtask

    task automatic pulse_start();
        @(negedge sys_clk) start = 1'b1;
        @(negedge sys_clk) start = 1'b0;
    endtask

    task automatic do_read(input logic [15:0] frame, input logic [15:0] exp);
        int  r0, m0, n;
        bit  got;
        sens_frame = frame;
        r0 = rise_cnt;
        m0 = mosi_bad;
        @(negedge sys_clk) start = 1'b1;
        @(posedge sys_clk) #1;
        check_eq("cs_low_after_start", adt_cs_n, 0);
        check_eq("busy_after_start", busy, 1);
        @(negedge sys_clk) start = 1'b0;
        n = 0;
        got = 1'b0;
        while (!got && n < 400) begin
            @(posedge sys_clk) #1;
            n++;
            got = temp_valid;
        end
        check_eq("valid_latency", n + 1, 205);
        check_eq("temp_data", temp_data, exp);
        check_eq("cs_high_at_end", adt_cs_n, 1);
        check_eq("busy_low_at_end", busy, 0);
        check_eq("sclk_rises", rise_cnt - r0, 16);
        check_eq("mosi_low", mosi_bad - m0, 0);
        @(posedge sys_clk) #1;
        check_eq("valid_one_cycle", temp_valid, 0);
    endtask

    task automatic wait_rises(input int r0, input int k);
        int n;
        n = 0;
        while ((rise_cnt - r0) < k && n < 400) begin
            @(negedge sys_clk);
            n++;
        end
        check_eq("reached_rise", (rise_cnt - r0) >= k, 1);
    endtask

    initial begin
        int f0, v0, r0, n;

        wait_cycles(3);
        #1;
        check_eq("rst_cs_n", adt_cs_n, 1);
        check_eq("rst_sclk", adt_sclk, 1);
        check_eq("rst_mosi", adt_mosi, 0);
        check_eq("rst_temp_data", temp_data, 16'h0000);
        check_eq("rst_valid", temp_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_aborted", aborted, 0);
        @(negedge sys_clk) sys_rst = 1'b1;

`ifdef ADT_AUTOPOLL_EN
        f0 = cs_falls;
        n = 0;
        while (cs_falls - f0 < 1 && n < 700) begin @(negedge sys_clk); n++; end
        wait_cycles(50);
        check_eq("busy_mid_poll", busy, 1);
        pulse_start();
        n = 0;
        while (cs_falls - f0 < 3 && n < 1500) begin @(negedge sys_clk); n++; end
        check_eq("poll_falls", cs_falls - f0, 3);
        check_eq("poll_gap_1", 32'(fall_t[(f0 + 1) % 16] - fall_t[f0 % 16]), 5000);
        check_eq("poll_gap_2", 32'(fall_t[(f0 + 2) % 16] - fall_t[(f0 + 1) % 16]), 5000);
`else
        f0 = cs_falls;
        wait_cycles(1000);
        check_eq("idle_no_cs", cs_falls - f0, 0);

        do_read(16'h0320, 16'h0320);
        do_read(16'h3B00, 16'hFB00);
        do_read(16'h3FFF, 16'hFFFF);

        // Abort after the 8th rising SCLK edge.
        sens_frame = 16'h0320;
        v0 = valid_cnt;
        r0 = rise_cnt;
        pulse_start();
        wait_rises(r0, 8);
        mcu_active = 1'b1;
        @(posedge sys_clk) #1;
        check_eq("abort_cs_n", adt_cs_n, 1);
        check_eq("abort_sclk", adt_sclk, 1);
        check_eq("abort_pulse", aborted, 1);
        check_eq("abort_busy", busy, 0);
        @(posedge sys_clk) #1;
        check_eq("abort_pulse_end", aborted, 0);
        check_eq("abort_keeps_data", temp_data, 16'hFFFF);

        // Start while the MCU owns the bus is dropped, not queued.
        f0 = cs_falls;
        pulse_start();
        wait_cycles(20);
        @(negedge sys_clk) mcu_active = 1'b0;
        wait_cycles(250);
        check_eq("mcu_block_cs", cs_falls - f0, 0);
        check_eq("abort_no_valid", valid_cnt - v0, 0);

        // Asynchronous reset in the middle of SHIFT.
        sens_frame = 16'h1234;
        v0 = valid_cnt;
        r0 = rise_cnt;
        pulse_start();
        wait_rises(r0, 4);
        #2 sys_rst = 1'b0;
        #1;
        check_eq("midrst_cs_n", adt_cs_n, 1);
        check_eq("midrst_sclk", adt_sclk, 1);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_data", temp_data, 16'h0000);
        check_eq("midrst_valid", temp_valid, 0);
        wait_cycles(3);
        @(negedge sys_clk) sys_rst = 1'b1;
        f0 = cs_falls;
        wait_cycles(250);
        check_eq("midrst_no_restart", cs_falls - f0, 0);
        check_eq("midrst_no_valid", valid_cnt - v0, 0);

        do_read(16'h0320, 16'h0320);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
